// File: rtl/gcd_rr_sched.sv
// Round-robin front end that shares one sequential GCD engine among NREQ requesters.
// One operand pair is in flight at a time; zero operands bypass the engine, and a
// watchdog turns a hung engine into an error response.
module gcd_rr_sched #(
    parameter  int NREQ    = 4,
    parameter  int W       = 7,
    parameter  int TIMEOUT = 32,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              eng_load,
    output logic [W-1:0]      eng_a,
    output logic [W-1:0]      eng_b,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_c
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            err_q, err_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_onehot;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Requester index successor with wrap at NREQ-1 (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
        if (x == IDW'(NREQ - 1)) begin
            return '0;
        end
        return x + IDW'(1);
    endfunction

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    assign grant_onehot = grant_found ? (NREQ'(1) << grant_idx) : '0;
    assign sel_a        = req_a[int'(grant_idx) * W +: W];
    assign sel_b        = req_b[int'(grant_idx) * W +: W];

    // Grant is only offered while idle and never while reset is held.
    assign req_ready = (state_q == S_IDLE && !rst) ? grant_onehot : '0;
    assign rsp_valid = (state_q == S_RESP);
    assign eng_load  = (state_q == S_LOAD);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign eng_a     = a_q;
    assign eng_b     = b_q;

    // Next-state and datapath updates for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    id_d    = grant_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = (sel_a == '0 || sel_b == '0) ? S_ZERO : S_LOAD;
                end
            end
            S_ZERO: begin
                // gcd(0,x)=x and gcd(0,0)=0 both reduce to a|b
                data_d  = a_q | b_q;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                // a done arriving on the terminal count still counts as success
                if (eng_done) begin
                    data_d  = eng_c;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = wrap_inc(id_q);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_gcd_rr_sched.sv
// Scoreboard bench for gcd_rr_sched with a behavioural engine model and a
// high-level round-robin / gcd reference.
module tb_gcd_rr_sched;

    localparam int NREQ    = 4;
    localparam int W       = 7;
    localparam int TIMEOUT = 32;
    localparam int IDW     = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              eng_load;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_done = 1'b0;
    logic [W-1:0]      eng_c = '0;

    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    typedef struct { int id; int data; bit err; } rsp_t;
    typedef struct { int a; int b; int dly; bit hang; bit spur; } eng_t;

    rsp_t sb[$];
    eng_t engq[$];

    int checks   = 0;
    int errors   = 0;
    int ptr_m    = 0;
    int load_cnt = 0;
    bit rdy_force = 1'b1;
    bit rdy_val   = 1'b1;

    gcd_rr_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_load(eng_load), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_c(eng_c)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    end

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return '0;
        return W'($urandom_range(1, (1 << W) - 1));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every presented response is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: id %0d data %0d err %0d, expected no response",
                             rsp_id, rsp_data, rsp_err);
                end else begin
                    chk("rsp_id", int'(rsp_id), sb[0].id);
                    chk("rsp_data", int'(rsp_data), sb[0].data);
                    chk("rsp_err", int'(rsp_err), int'(sb[0].err));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Load strobe must be a single-cycle pulse.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_load) begin
                load_cnt++;
                chk("eng_load_width", int'(prev), 0);
            end
            prev = eng_load;
        end
    end

    // Engine model: gcd of its operands, done during RUN cycle dly, optional spurious
    // done during the load cycle, or never done when hung.
    initial begin
        eng_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (eng_load) begin
                if (engq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: eng_a %0d eng_b %0d, expected no load", eng_a, eng_b);
                    e = '{a: int'(eng_a), b: int'(eng_b), dly: 0, hang: 1'b1, spur: 1'b0};
                end else begin
                    e = engq.pop_front();
                end
                chk("eng_a", int'(eng_a), e.a);
                chk("eng_b", int'(eng_b), e.b);
                c = ref_gcd(int'(eng_a), int'(eng_b));
                if (e.spur) begin
                    eng_done = 1'b1;
                    eng_c    = W'(c) ^ W'(42);
                end
                @(posedge clk);
                #1;
                eng_done = 1'b0;
                eng_c    = W'($urandom);
                if (!e.hang) begin
                    if (e.dly > 1) begin
                        repeat (e.dly - 1) @(posedge clk);
                        #1;
                    end
                    eng_done = 1'b1;
                    eng_c    = W'(c);
                    @(posedge clk);
                    #1;
                    eng_done = 1'b0;
                end
            end
        end
    end

    // Consumer: forced level or random backpressure, changed just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Present a request mask, predict the round-robin winner and its response,
    // and wait for the accept. Returns at the start of the cycle after the accept.
    task automatic issue(input logic [NREQ-1:0] mask, input bit keep, input bit exp_en,
                         input int dly, input bit hang, input bit spur, output int dut_g);
        int   n;
        int   g;
        int   a;
        int   b;
        bit   z;
        rsp_t r;
        eng_t e;
        @(posedge clk);
        #1;
        req_valid = mask;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && mask[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 400);
        dut_g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) dut_g = k;
        end
        chk("grant", int'(req_ready), 1 << g);
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end
        a = int'(opa[g]);
        b = int'(opb[g]);
        z = (a == 0 || b == 0);
        if (exp_en) begin
            r.id   = g;
            r.data = z ? (a | b) : (hang ? 0 : ref_gcd(a, b));
            r.err  = !z && hang;
            sb.push_back(r);
            ptr_m = (g + 1) % NREQ;
        end
        if (!z) begin
            e = '{a: a, b: b, dly: dly, hang: hang, spur: spur};
            engq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (keep) begin
            opa[g] = rnd_op();
            opb[g] = rnd_op();
        end else begin
            req_valid[g] = 1'b0;
        end
    endtask

    // Cycles from accept until rsp_valid, counting the cycle after accept as 1.
    task automatic wait_rsp(input int exp_lat, input int n0, input string nm);
        int n;
        n = n0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 400);
        chk(nm, n, exp_lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses still outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int gd;
        int lc;
        logic [NREQ-1:0] m;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'(i + 5);
            opb[i] = W'(i + 9);
        end

        // Reset state: everything low even with all requesters valid.
        req_valid = '1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_eng_load", int'(eng_load), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_eng_a", int'(eng_a), 0);
        chk("rst_eng_b", int'(eng_b), 0);
        req_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // All requesters continuously valid: grants rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'($urandom_range(1, 127));
            opb[i] = W'($urandom_range(1, 127));
        end
        for (int t = 0; t < 5; t++) begin
            issue('1, 1'b1, 1'b1, $urandom_range(1, 6), 1'b0, 1'b0, gd);
            chk("rr_order", gd, t % NREQ);
        end
        req_valid = '0;
        drain();

        // Single requester through the engine.
        opa[1] = 7'd12;
        opb[1] = 7'd18;
        issue(4'b0010, 1'b0, 1'b1, 5, 1'b0, 1'b0, gd);
        @(negedge clk);
        chk("t1_eng_load", int'(eng_load), 1);
        chk("t1_eng_a", int'(eng_a), 12);
        chk("t1_eng_b", int'(eng_b), 18);
        wait_rsp(7, 1, "t1_latency");
        chk("t1_rsp_data", int'(rsp_data), 6);
        chk("t1_rsp_id", int'(rsp_id), 1);
        drain();

        // Zero operands bypass the engine.
        lc = load_cnt;
        opa[2] = 7'd0;
        opb[2] = 7'd35;
        issue(4'b0100, 1'b0, 1'b1, 1, 1'b0, 1'b0, gd);
        wait_rsp(2, 0, "zero_latency");
        chk("zero_rsp_data", int'(rsp_data), 35);
        chk("zero_rsp_id", int'(rsp_id), 2);
        drain();
        opa[2] = 7'd0;
        opb[2] = 7'd0;
        issue(4'b0100, 1'b0, 1'b1, 1, 1'b0, 1'b0, gd);
        wait_rsp(2, 0, "zero0_latency");
        chk("zero0_rsp_data", int'(rsp_data), 0);
        drain();
        opa[0] = 7'd9;
        opb[0] = 7'd0;
        issue(4'b0001, 1'b0, 1'b1, 1, 1'b0, 1'b0, gd);
        drain();
        chk("zero_no_load", load_cnt, lc);

        // Watchdog abort, done on the terminal cycle, and done during load ignored.
        opa[3] = 7'd14;
        opb[3] = 7'd21;
        issue(4'b1000, 1'b0, 1'b1, 0, 1'b1, 1'b0, gd);
        wait_rsp(TIMEOUT + 2, 0, "timeout_latency");
        chk("timeout_err", int'(rsp_err), 1);
        chk("timeout_data", int'(rsp_data), 0);
        drain();
        opa[0] = 7'd30;
        opb[0] = 7'd45;
        issue(4'b0001, 1'b0, 1'b1, TIMEOUT, 1'b0, 1'b0, gd);
        wait_rsp(TIMEOUT + 2, 0, "lastcycle_latency");
        chk("lastcycle_err", int'(rsp_err), 0);
        chk("lastcycle_data", int'(rsp_data), 15);
        drain();
        opa[1] = 7'd40;
        opb[1] = 7'd24;
        issue(4'b0010, 1'b0, 1'b1, 3, 1'b0, 1'b1, gd);
        wait_rsp(5, 0, "spur_latency");
        chk("spur_data", int'(rsp_data), 8);
        drain();

        // Backpressure: response held, no grants, waiting requester served afterwards.
        rdy_val = 1'b0;
        opa[0] = 7'd50;
        opb[0] = 7'd75;
        opa[3] = 7'd27;
        opb[3] = 7'd36;
        issue(4'b0001, 1'b0, 1'b1, 2, 1'b0, 1'b0, gd);
        wait_rsp(4, 0, "bp_latency");
        req_valid[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        rdy_val = 1'b1;
        issue(4'b1000, 1'b0, 1'b1, 4, 1'b0, 1'b0, gd);
        chk("bp_next_grant", gd, 3);
        drain();

        // Reset in RUN aborts silently and returns the pointer to 0.
        opa[1] = 7'd33;
        opb[1] = 7'd22;
        issue(4'b0010, 1'b0, 1'b1, 3, 1'b0, 1'b0, gd);
        drain();
        opa[2] = 7'd20;
        opb[2] = 7'd8;
        issue(4'b0100, 1'b0, 1'b0, 15, 1'b0, 1'b0, gd);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        ptr_m = 0;
        req_valid = '1;
        @(negedge clk);
        chk("rrst_req_ready", int'(req_ready), 0);
        chk("rrst_rsp_valid", int'(rsp_valid), 0);
        chk("rrst_eng_load", int'(eng_load), 0);
        chk("rrst_rsp_id", int'(rsp_id), 0);
        chk("rrst_rsp_data", int'(rsp_data), 0);
        chk("rrst_rsp_err", int'(rsp_err), 0);
        chk("rrst_eng_a", int'(eng_a), 0);
        chk("rrst_eng_b", int'(eng_b), 0);
        req_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("rrst_no_rsp", int'(rsp_valid), 0);
        end
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'($urandom_range(1, 127));
            opb[i] = W'($urandom_range(1, 127));
        end
        issue('1, 1'b0, 1'b1, 4, 1'b0, 1'b0, gd);
        chk("rrst_first_grant", gd, 0);
        req_valid = '0;
        drain();

        // Randomized traffic with random backpressure.
        rdy_force = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = rnd_op();
                opb[i] = rnd_op();
            end
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            issue(m, 1'b0, 1'b1, $urandom_range(1, TIMEOUT), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), gd);
        end
        req_valid = '0;
        drain();
        chk("sb_empty", sb.size(), 0);
        chk("engq_empty", engq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
